commit_trace_fifo: RTL and testbench
====================================

// Module: commit_trace_fifo
// PURPOSE
//  Parametrised commit-trace buffer between a multi-issue CPU core and the debug/difftest port.
//  Accepts up to LANES commit records per cycle and compacts them in program order into a FIFO.
//  Drains one record per cycle over a valid/ready handshake.
//  Freezes intake once a halt instruction commits, so the trace ends exactly at the halt.
// PARAMETERS
//  LANES   2    commit lanes per cycle; legal 1..4; lane 0 is oldest
//  DEPTH   8    FIFO entries; power of 2, DEPTH >= 2*LANES
//  REC_W   168  record width; fixed layout, MSB->LSB:
//               {pc[32], inst[32], halt[1], reg_we[1], reg_wa[5], reg_wd[32], dmem_we[1], dmem_wa[32], dmem_wd[32]}
// PORTS
//  clk             in   1              clock; all state on posedge
//  rst             in   1              synchronous reset, ACTIVE-LOW (0 = reset)
//  global_en       in   1              core enable; gates the push side only
//  in_valid        in   LANES          per-lane commit valid; any bit pattern allowed
//  in_rec          in   LANES*REC_W    lane i occupies bits [i*REC_W +: REC_W]
//  in_ready        out  1              core may commit this cycle; core stalls when 0
//  out_valid       out  1              head record present
//  out_ready       in   1              consumer takes head record
//  commit_pc       out  32             head record fields; all fields 0 when out_valid = 0
//  commit_inst     out  32
//  commit_halt     out  1
//  commit_reg_we   out  1
//  commit_reg_wa   out  5
//  commit_reg_wd   out  32
//  commit_dmem_we  out  1
//  commit_dmem_wa  out  32
//  commit_dmem_wd  out  32
//  level           out  $clog2(DEPTH+1)  occupied entries
//  halted          out  1              halt record accepted; intake frozen
//  halt_done       out  1              halted && level == 0 (trace fully drained)
//  commit_cnt      out  32             records popped since reset; wraps at 2^32
// BEHAVIOUR
//  Reset (rst = 0 at posedge):
//   - Clear rd/wr pointers, level, halted, commit_cnt.
//   - Resulting outputs: out_valid = 0, in_ready = 1, all commit_* = 0, halt_done = 0.
//   - Reset mid-operation discards buffered records; RAM contents need not be cleared.
//  Readiness: in_ready = !halted && (DEPTH - level) >= LANES.
//   - Based on the start-of-cycle level only; a same-cycle pop does not raise in_ready.
//   - No bypass in either direction.
//  Push: push = global_en && in_ready && |in_valid.
//   - Valid lanes are written in ascending lane order to consecutive slots starting at wr_ptr.
//   - Invalid lanes leave no hole (e.g. in_valid = 4'b1010 writes lane1 then lane3).
//   - wr_ptr and level advance by the number of kept lanes.
//   - in_valid with in_ready = 0 or global_en = 0: nothing is written, no state changes.
//  Halt:
//   - If a kept lane has halt = 1, that lane is written.
//   - All higher lanes in the same cycle are discarded.
//   - halted <= 1 on the same edge and stays set until reset.
//  Pop:
//   - pop = out_valid && out_ready; independent of global_en, so draining is possible while the core is frozen.
//   - rd_ptr +1, level -1, commit_cnt +1.
//   - Head fields update combinationally from the RAM at the new rd_ptr.
//  Latency: a record pushed at edge N shows on out_valid after edge N (1 cycle), even if the FIFO was empty.
//  Simultaneous push and pop: level_next = level + kept - pop; pointers are independent.
//  Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH; level alone distinguishes full from empty.
//  Holding: out_valid && !out_ready holds the head record stable (consumer-side handshake rule).
//  Width rules: kept-lane count is a popcount of at most LANES; level never exceeds DEPTH by construction.
//  Every push edge has in_ready = 1 beforehand, which guarantees >= LANES free entries.
// TESTING
//  1. Reset: hold rst = 0 for 2 cycles with in_valid = 2'b11
//     -> level = 0, out_valid = 0, commit_* = 0, in_ready = 1 after release.
//  2. Compaction: LANES = 2, in_valid = 2'b10, lane1 pc = 0x104, out_ready = 0
//     -> level = 1, commit_pc = 0x104 next cycle; then in_valid = 2'b11, pcs 0x108/0x10C -> level = 3, order 104, 108, 10C.
//  3. Backpressure: out_ready = 0, push pairs until level = 7 (DEPTH = 8)
//     -> in_ready = 0; further in_valid is ignored and level stays 7.
//     Then pop one with a push offered in the same cycle -> that push is not taken; level = 6.
//  4. Halt mid-bundle: in_valid = 2'b11, lane0 halt = 1, lane1 pc = 0x200
//     -> only lane0 stored, halted = 1, in_ready = 0; drain -> halt_done = 1, commit_halt = 1 on the last pop, 0x200 never emitted.
//  5. Wrap and concurrency: 40 random cycles of push/pop with random out_ready
//     -> output pc sequence equals the scoreboard; commit_cnt equals the number of pops; pointers wrap past 7 without loss.
//  6. Freeze: global_en = 0, in_valid = 2'b11, out_ready = 1, level = 3
//     -> no push, 3 pops, level = 0, out_valid = 0.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// Commit-trace buffer: compacts up to LANES in-order commit records per cycle into a FIFO
// and drains one record per cycle; intake freezes permanently once a halt record is accepted.
module commit_trace_fifo #(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int REC_W = 168
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         global_en,
    input  logic [LANES-1:0]             in_valid,
    input  logic [LANES*REC_W-1:0]       in_rec,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  commit_pc,
    output logic [31:0]                  commit_inst,
    output logic                         commit_halt,
    output logic                         commit_reg_we,
    output logic [4:0]                   commit_reg_wa,
    output logic [31:0]                  commit_reg_wd,
    output logic                         commit_dmem_we,
    output logic [31:0]                  commit_dmem_wa,
    output logic [31:0]                  commit_dmem_wd,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         halted,
    output logic                         halt_done,
    output logic [31:0]                  commit_cnt
);
    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = $clog2(DEPTH+1);
    localparam int HALT_BIT = REC_W - 65;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             halted_q, halted_d;
    logic [31:0]      commit_cnt_q, commit_cnt_d;

    logic [LANES-1:0] keep;
    logic [AW-1:0]    lane_off [LANES];
    logic [AW-1:0]    run;
    logic [LW-1:0]    kept_cnt;
    logic             halt_hit;
    logic             push, pop;
    logic [REC_W-1:0] head;

    // Compaction: each kept lane lands at wr_ptr + (number of kept lanes below it).
    // Lanes after a kept halt record are dropped.
    always_comb begin
        keep     = '0;
        run      = '0;
        kept_cnt = '0;
        halt_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_off[i] = run;
            if (in_valid[i] && !halt_hit) begin
                keep[i]  = 1'b1;
                run      = run + AW'(1);
                kept_cnt = kept_cnt + LW'(1);
                if (in_rec[i*REC_W + HALT_BIT]) halt_hit = 1'b1;
            end
        end
    end

    // Readiness uses the start-of-cycle level only; no bypass from a same-cycle pop.
    assign in_ready  = !halted_q && (level_q <= LW'(DEPTH - LANES));
    assign out_valid = (level_q != '0);
    assign push      = global_en && in_ready && (|in_valid);
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        halted_d     = halted_q;
        commit_cnt_d = commit_cnt_q;
        level_d      = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(kept_cnt);
            level_d  = level_d + kept_cnt;
            if (halt_hit) halted_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            level_d      = level_d - LW'(1);
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            halted_q     <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            halted_q     <= halted_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    // Storage is not reset; level gates everything that reads it.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < LANES; i++) begin
                if (keep[i]) mem_q[wr_ptr_q + lane_off[i]] <= in_rec[i*REC_W +: REC_W];
            end
        end
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign commit_pc      = head[REC_W-1   -: 32];
    assign commit_inst    = head[REC_W-33  -: 32];
    assign commit_halt    = head[HALT_BIT];
    assign commit_reg_we  = head[REC_W-66];
    assign commit_reg_wa  = head[REC_W-67  -: 5];
    assign commit_reg_wd  = head[REC_W-72  -: 32];
    assign commit_dmem_we = head[REC_W-104];
    assign commit_dmem_wa = head[REC_W-105 -: 32];
    assign commit_dmem_wd = head[REC_W-137 -: 32];

    assign level      = level_q;
    assign halted     = halted_q;
    assign halt_done  = halted_q && (level_q == '0);
    assign commit_cnt = commit_cnt_q;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: directed scenarios plus random push/pop traffic,
// all outputs compared each cycle against a queue-based reference model.
module tb_commit_trace_fifo;
    localparam int LANES    = 2;
    localparam int DEPTH    = 8;
    localparam int REC_W    = 168;
    localparam int LW       = $clog2(DEPTH+1);
    localparam int HALT_BIT = REC_W - 65;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       global_en;
    logic [LANES-1:0]           in_valid;
    logic [LANES*REC_W-1:0]     in_rec;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                commit_pc, commit_inst, commit_reg_wd;
    logic [31:0]                commit_dmem_wa, commit_dmem_wd;
    logic                       commit_halt, commit_reg_we, commit_dmem_we;
    logic [4:0]                 commit_reg_wa;
    logic [LW-1:0]              level;
    logic                       halted, halt_done;
    logic [31:0]                commit_cnt;

    commit_trace_fifo #(.LANES(LANES), .DEPTH(DEPTH), .REC_W(REC_W)) dut (
        .clk(clk), .rst(rst), .global_en(global_en),
        .in_valid(in_valid), .in_rec(in_rec), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_halt(commit_halt),
        .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa),
        .commit_reg_wd(commit_reg_wd), .commit_dmem_we(commit_dmem_we),
        .commit_dmem_wa(commit_dmem_wa), .commit_dmem_wd(commit_dmem_wd),
        .level(level), .halted(halted), .halt_done(halt_done), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: ordered list of buffered records plus halt flag and pop count.
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] lane_rec [LANES];
    bit               m_halted;
    bit               m_known;
    int unsigned      m_cnt;
    int               n_checks;
    int               n_errors;

    task automatic check(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] make_rec(input logic [31:0] pc, input logic halt);
        logic [31:0] inst, rwd, dwa, dwd;
        logic [4:0]  rwa;
        logic        rwe, dwe;
        inst = $urandom(); rwd = $urandom(); dwa = $urandom(); dwd = $urandom();
        rwa  = 5'($urandom_range(0, 31));
        rwe  = 1'($urandom_range(0, 1));
        dwe  = 1'($urandom_range(0, 1));
        return {pc, inst, halt, rwe, rwa, rwd, dwe, dwa, dwd};
    endfunction

    // Driver: lane i carries pc = base + 4*i; halt_lane < 0 means no halt record.
    task automatic drive(input logic [LANES-1:0] v, input logic [31:0] base, input int halt_lane,
                         input logic en, input logic ordy);
        for (int i = 0; i < LANES; i++) begin
            lane_rec[i] = make_rec(base + 32'(4*i), (i == halt_lane));
            in_rec[i*REC_W +: REC_W] = lane_rec[i];
        end
        in_valid  = v;
        global_en = en;
        out_ready = ordy;
    endtask

    task automatic step();
        logic [REC_W-1:0] exp_head, obs_head;
        bit m_rdy, m_push, m_pop;
        @(negedge clk);
        m_rdy = !m_halted && ((DEPTH - exp_q.size()) >= LANES);
        if (m_known) begin
            exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
            obs_head = {commit_pc, commit_inst, commit_halt, commit_reg_we, commit_reg_wa,
                        commit_reg_wd, commit_dmem_we, commit_dmem_wa, commit_dmem_wd};
            check("in_ready",   REC_W'(in_ready),   REC_W'(m_rdy));
            check("out_valid",  REC_W'(out_valid),  REC_W'(exp_q.size() > 0));
            check("level",      REC_W'(level),      REC_W'(exp_q.size()));
            check("head",       obs_head,           exp_head);
            check("halted",     REC_W'(halted),     REC_W'(m_halted));
            check("halt_done",  REC_W'(halt_done),  REC_W'(m_halted && exp_q.size() == 0));
            check("commit_cnt", REC_W'(commit_cnt), REC_W'(m_cnt));
        end
        m_pop  = (exp_q.size() > 0) && out_ready;
        m_push = global_en && m_rdy && (|in_valid);
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            m_halted = 0;
            m_cnt    = 0;
            m_known  = 1;
        end else if (m_known) begin
            if (m_pop) begin
                void'(exp_q.pop_front());
                m_cnt++;
            end
            if (m_push) begin
                for (int i = 0; i < LANES; i++) begin
                    if (in_valid[i]) begin
                        exp_q.push_back(lane_rec[i]);
                        if (lane_rec[i][HALT_BIT]) begin
                            m_halted = 1;
                            break;
                        end
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(2'b11, 32'h0, -1, 1'b1, 1'b0);
        step();
        step();
        rst = 1'b1;
        drive(2'b00, 32'h0, -1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        n_checks = 0; n_errors = 0; m_known = 0; m_halted = 0; m_cnt = 0;
        rst = 1'b0; global_en = 1'b1; in_valid = '0; in_rec = '0; out_ready = 1'b0;
        #1;

        // Reset with lanes asserted
        do_reset();
        step();
        check("rst_level", REC_W'(level), '0);
        check("rst_in_ready", REC_W'(in_ready), REC_W'(1));

        // Compaction: lane1 only, then both lanes
        drive(2'b10, 32'h100, -1, 1'b1, 1'b0); step();
        drive(2'b00, 32'h0, -1, 1'b1, 1'b0);   step();
        check("compact_pc", REC_W'(commit_pc), REC_W'(32'h104));
        drive(2'b11, 32'h108, -1, 1'b1, 1'b0); step();

        // Backpressure up to level 7, then ignored offers, then pop with an offered push
        drive(2'b11, 32'h110, -1, 1'b1, 1'b0); step();
        drive(2'b11, 32'h118, -1, 1'b1, 1'b0); step();
        drive(2'b11, 32'h120, -1, 1'b1, 1'b0); step();
        drive(2'b11, 32'h128, -1, 1'b1, 1'b0); step();
        check("bp_level", REC_W'(level), REC_W'(7));
        drive(2'b11, 32'h130, -1, 1'b1, 1'b1); step();
        drive(2'b00, 32'h0, -1, 1'b1, 1'b0);   step();
        check("bp_pop_level", REC_W'(level), REC_W'(6));
        drive(2'b00, 32'h0, -1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step();

        // Halt in lane0 with a younger lane1 record that must be discarded
        drive(2'b11, 32'h1FC, 0, 1'b1, 1'b0);
        lane_rec[1] = make_rec(32'h200, 1'b0);
        in_rec[REC_W +: REC_W] = lane_rec[1];
        step();
        drive(2'b11, 32'h300, -1, 1'b1, 1'b0); step();
        check("halt_level", REC_W'(level), REC_W'(1));
        check("halt_pc", REC_W'(commit_pc), REC_W'(32'h1FC));
        drive(2'b11, 32'h300, -1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check("halt_done", REC_W'(halt_done), REC_W'(1));

        // Random concurrent push/pop traffic with pointer wrap
        do_reset();
        pc = 32'h1000;
        for (int i = 0; i < 40; i++) begin
            drive(LANES'($urandom_range(0, 3)), pc, -1, 1'b1, 1'($urandom_range(0, 1)));
            pc += 32'h10;
            step();
        end
        drive(2'b00, 32'h0, -1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step();

        // Freeze: core disabled while the buffer drains
        drive(2'b11, pc, -1, 1'b1, 1'b0);         step();
        drive(2'b01, pc + 32'h10, -1, 1'b1, 1'b0); step();
        drive(2'b11, pc + 32'h20, -1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check("freeze_level", REC_W'(level), '0);
        check("freeze_valid", REC_W'(out_valid), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
